// File: rtl/sys_timer_pkg.sv
// Shared constants and FSM encoding for the sys_timer scheduler.
package sys_timer_pkg;

    localparam logic [2:0] ST_ADDR_STATUS = 3'd0;
    localparam logic [2:0] ST_ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ST_ADDR_PERL   = 3'd2;
    localparam logic [2:0] ST_ADDR_PERH   = 3'd3;

    localparam logic [15:0] ST_CTRL_ITO   = 16'h0001;
    localparam logic [15:0] ST_CTRL_CONT  = 16'h0002;
    localparam logic [15:0] ST_CTRL_START = 16'h0004;
    localparam logic [15:0] ST_CTRL_STOP  = 16'h0008;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_STOP,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_VFY_RD,
        S_VFY_CHK,
        S_RUN,
        S_ACK,
        S_ACK_WAIT
    } sched_state_t;

endpackage

// File: rtl/sys_timer_sched_tick_channel.sv
// One reloadable down-counting tick channel; pulses expire when the count runs out.
module tick_channel #(
    parameter int CH_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            enable,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_reload,
    output logic            expire
);

    logic [CH_W-1:0] reload;
    logic [CH_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload <= '0;
            count  <= '0;
            expire <= 1'b0;
        end else begin
            expire <= 1'b0;
            // A config write beats a coincident tick and suppresses its event.
            if (cfg_we) begin
                reload <= cfg_reload;
                count  <= cfg_reload;
            end else if (tick && enable) begin
                if (count == '0) begin
                    count <= reload;
                end else if (count == CH_W'(1)) begin
                    expire <= 1'b1;
                    count  <= reload;
                end else begin
                    count <= count - CH_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sys_timer_sched.sv
// Avalon-MM master that programs sys_timer, verifies RUN, acks every IRQ
// and fans the resulting ticks out to NUM_CH down-counting channels.
module sys_timer_sched
    import sys_timer_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic [15:0]       tmr_readdata,
    input  logic              tmr_irq,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              ch_cfg_we,
    input  logic [2:0]        ch_cfg_sel,
    input  logic [CH_W-1:0]   ch_cfg_reload,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic [NUM_CH-1:0] ch_event,
    output logic [31:0]       tick_count,
    output logic              running,
    output logic              err
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    sched_state_t       state, state_nxt;
    logic [31:0]        period_q;
    logic [RETRY_W-1:0] retry_q;
    logic               stop_pend;
    logic               honour, stop_go, start_go, tick;
    logic               unused_rd;

    assign unused_rd = ^{tmr_readdata[15:2], tmr_readdata[0]};

    // Host commands only land in quiescent states; elsewhere they are dropped.
    assign honour   = (state == S_IDLE) || (state == S_RUN) || (state == S_ACK_WAIT);
    assign stop_go  = honour && cfg_stop;
    assign start_go = honour && cfg_start && !cfg_stop;
    assign tick     = (state == S_ACK_WAIT) && !stop_go && !start_go;
    assign running  = (state == S_RUN) || (state == S_ACK) || (state == S_ACK_WAIT);

    always_comb begin
        state_nxt      = state;
        tmr_address    = ST_ADDR_STATUS;
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_writedata  = '0;
        case (state)
            S_WR_STOP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ST_ADDR_CTRL;
                tmr_writedata  = ST_CTRL_STOP;
                state_nxt      = stop_pend ? S_IDLE : S_WR_PL;
            end
            S_WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ST_ADDR_PERL;
                tmr_writedata  = period_q[15:0];
                state_nxt      = S_WR_PH;
            end
            S_WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ST_ADDR_PERH;
                tmr_writedata  = period_q[31:16];
                state_nxt      = S_WR_CTRL;
            end
            S_WR_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ST_ADDR_CTRL;
                tmr_writedata  = ST_CTRL_ITO | ST_CTRL_CONT | ST_CTRL_START;
                state_nxt      = S_VFY_RD;
            end
            S_VFY_RD: begin
                tmr_chipselect = 1'b1;
                state_nxt      = S_VFY_CHK;
            end
            S_VFY_CHK: begin
                if (tmr_readdata[1])                      state_nxt = S_RUN;
                else if (retry_q < RETRY_W'(MAX_RETRY))   state_nxt = S_WR_CTRL;
                else                                      state_nxt = S_IDLE;
            end
            S_RUN:      if (tmr_irq) state_nxt = S_ACK;
            S_ACK: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                state_nxt      = S_ACK_WAIT;
            end
            S_ACK_WAIT: state_nxt = S_RUN;
            default:    state_nxt = S_IDLE;
        endcase
        if (stop_go || start_go) state_nxt = S_WR_STOP;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            period_q   <= '0;
            retry_q    <= '0;
            stop_pend  <= 1'b0;
            err        <= 1'b0;
            tick_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WR_STOP) stop_pend <= 1'b0;
            if (stop_go) stop_pend <= 1'b1;
            if (start_go) begin
                period_q  <= cfg_period;
                stop_pend <= 1'b0;
                retry_q   <= '0;
                err       <= 1'b0;
            end
            if (state == S_VFY_CHK) begin
                if (tmr_readdata[1]) begin
                    retry_q <= '0;
                end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                    retry_q <= retry_q + RETRY_W'(1);
                end else begin
                    retry_q <= '0;
                    err     <= 1'b1;
                end
            end
            if (tick) tick_count <= tick_count + 32'd1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(.CH_W(CH_W)) u_ch (
            .clk        (clk),
            .rst_n      (reset_n),
            .tick       (tick),
            .enable     (ch_enable[i]),
            .cfg_we     (ch_cfg_we && (ch_cfg_sel == 3'(i))),
            .cfg_reload (ch_cfg_reload),
            .expire     (ch_event[i])
        );
    end

endmodule

// File: doc/sys_timer_sched.md
Name: sys_timer_sched

Overview:
- Avalon-MM master that programs and services the 16-bit-bus interval timer (`sys_timer`) autonomously.
- Loads the 32-bit period, starts the timer in continuous mode, and verifies the RUN status bit.
- Acknowledges every timeout IRQ in hardware and fans the resulting tick out to NUM_CH software-style down-counting channels.
- Removes all timer ISR work from the Nios CPU; sits between the CPU config registers and the `sys_timer` s1 slave.

Parameters:
- NUM_CH, 4, number of tick channels (1..8).
- CH_W, 16, channel reload/count width.
- MAX_RETRY, 3, verify-read retries before flagging an error.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tmr_address  out  3  timer slave address
- tmr_chipselect  out  1  timer chipselect
- tmr_write_n  out  1  timer write strobe, active low
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data; registered, valid the cycle after the address is presented
- tmr_irq  in  1  timer interrupt
- cfg_period  in  32  period value, sampled on cfg_start
- cfg_start  in  1  one-cycle pulse: (re)program and start
- cfg_stop  in  1  one-cycle pulse: stop timer
- ch_cfg_we  in  1  channel reload write strobe
- ch_cfg_sel  in  3  channel index
- ch_cfg_reload  in  CH_W  reload value (ticks)
- ch_enable  in  NUM_CH  per-channel enable
- ch_event  out  NUM_CH  one-cycle pulse on channel expiry
- tick_count  out  32  total acknowledged ticks, wraps
- running  out  1  high in RUN/ACK/ACK_WAIT
- err  out  1  sticky: verify failed MAX_RETRY times; cleared by cfg_start

Behaviour:
- Reset values:
  - all outputs 0; tmr_write_n=1; state IDLE.
  - channel counters and reloads 0; period latch 0; retry count 0.
- Bus rules:
  - Exactly one access per bus state; chipselect high only in bus states.
  - Writes complete in one cycle; no waitrequest.
  - Timer register map: 0 status (bit0 TO, bit1 RUN), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h.
- FSM (one state per cycle unless noted):
  - IDLE: on cfg_start → WR_STOP, latching cfg_period.
  - WR_STOP: write addr1 = 0x0008 → WR_PL.
  - WR_PL: write addr2 = period[15:0] → WR_PH.
  - WR_PH: write addr3 = period[31:16] → WR_CTRL.
  - WR_CTRL: write addr1 = 0x0007. The period writes force the timer into stop, so START must follow them. → VFY_RD.
  - VFY_RD: read addr0 (chipselect=1, write_n=1) → VFY_CHK.
  - VFY_CHK: sample tmr_readdata[1].
    - 1 → RUN, retry count cleared.
    - 0 and retries < MAX_RETRY → WR_CTRL, retry++.
    - otherwise err=1 → IDLE.
  - RUN: tmr_irq=1 → ACK.
  - ACK: write addr0 = 0x0000 (clears TO) → ACK_WAIT.
  - ACK_WAIT: one dead cycle so the irq de-asserts.
    - tick_count++.
    - Every channel with its enable bit set is processed as below.
    - → RUN.
- Priority:
  - cfg_stop outranks cfg_start.
  - Both outrank irq.
  - Both are honoured only in IDLE, RUN, or ACK_WAIT; in other states they are ignored, not queued.
  - cfg_stop in RUN/ACK_WAIT → WR_STOP → IDLE. The stop path skips the period writes: WR_STOP goes to IDLE when a stop is pending.
  - cfg_start in RUN/ACK_WAIT → full reprogram from WR_STOP. It does not increment tick_count.
- Channel tick processing (enabled channel):
  - count==0 → load reload, no event.
  - count==1 → ch_event pulse, load reload.
  - otherwise → decrement.
  - reload==0 keeps the channel silent.
- Channel config:
  - ch_cfg_we writes the reload and also loads the count immediately.
  - If ch_cfg_we coincides with a tick on the same channel, the config write wins and no event fires.
  - ch_cfg_sel ≥ NUM_CH is ignored.
- Disabled channels hold their count.
- tick_count wraps 0xFFFFFFFF → 0.

Decomposition:
- Package sys_timer_pkg holds:
  - timer address constants (ST_ADDR_STATUS=0, CTRL=1, PERL=2, PERH=3);
  - control bit masks (ITO, CONT, START, STOP);
  - the FSM state enum.
- Sub-module tick_channel: one CH_W down-counter with reload and event output; instantiated NUM_CH times.

Test Plan:
1. Reset, then cfg_start with cfg_period=0x0001387F.
   - Bus sequence: (1,0x0008), (2,0x387F), (3,0x0001), (1,0x0007), then a read of addr0.
   - RUN bit set in the model → running=1 seven cycles after cfg_start.
2. In RUN, assert tmr_irq.
   - Next cycle: write addr0 = 0.
   - tick_count 0→1 in ACK_WAIT; second irq → 2.
3. Channel 2 reload=3, enabled; 6 ticks.
   - ch_event[2] pulses on ticks 3 and 6 only.
   - Channel 0 (reload 0) never fires.
4. Model reports RUN=0 forever.
   - Four WR_CTRL writes total (initial + 3 retries), then err=1, state IDLE.
   - A following cfg_start clears err.
5. cfg_stop in RUN with irq also high.
   - Write (1,0x0008), then IDLE, running=0.
   - No status write and tick_count unchanged.
6. Assert reset_n low mid-WR_PH.
   - All outputs 0 asynchronously and tmr_write_n=1.
   - Restart programs the full sequence from WR_STOP.
